// File: rtl/renkon_accum.sv
`default_nettype none
// ============================================================================
// Module   : renkon_accum
// Purpose  : Output-side accumulator for renkon_conv. Sums the per-input-
//            channel partial-sum pixel stream of one output map in an
//            internal buffer. On the last input channel it adds the bias,
//            saturates to DWIDTH bits and emits an addressed write stream
//            to output memory.
//
// Ports    : clk         system clock, rising edge
//            xrst        asynchronous active-low reset
//            start       one-cycle job start pulse (accepted only while idle)
//            in_size     number of input channels (1..2**CWIDTH-1), latched
//            pix_size    pixels per map (1..2**LWIDTH), latched
//            bias        signed bias of this output map, latched
//            conv_valid  conv_data carries one partial-sum pixel
//            conv_data   signed partial sum from renkon_conv
//            ack         high while idle and able to accept start
//            out_valid   write enable towards output memory
//            out_addr    pixel index of out_data
//            out_data    saturated final pixel
//            done        one-cycle pulse with the last out_valid of a job
//
// Options  : RENKON_ACCUM_RELU_EN - when defined, negative saturated results
//            are clamped to zero (fused ReLU) with no added latency.
//
// Revision : 1.0 - initial release
// ============================================================================
module renkon_accum #(
    parameter int DWIDTH = 16,
    parameter int LWIDTH = 10,
    parameter int CWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     start,
    input  logic [CWIDTH-1:0]        in_size,
    input  logic [LWIDTH:0]          pix_size,
    input  logic signed [DWIDTH-1:0] bias,
    input  logic                     conv_valid,
    input  logic signed [DWIDTH-1:0] conv_data,
    output logic                     ack,
    output logic                     out_valid,
    output logic [LWIDTH-1:0]        out_addr,
    output logic signed [DWIDTH-1:0] out_data,
    output logic                     done
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    // Buffer entries carry CWIDTH guard bits so that summing up to
    // 2**CWIDTH-1 channels of full-scale partial sums cannot overflow.
    localparam int c_BWIDTH = DWIDTH + CWIDTH;
    // Final sum adds bias on top of the buffer value: one more guard bit.
    localparam int c_SWIDTH = c_BWIDTH + 1;
    localparam int c_DEPTH  = 1 << LWIDTH;
    // Bits that must all agree for the final sum to fit in DWIDTH signed.
    localparam int c_HWIDTH = c_SWIDTH - DWIDTH + 1;

    localparam logic [DWIDTH-1:0] c_SAT_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] c_SAT_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

    // State encoding
    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_ACC  = 1'b1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [CWIDTH-1:0]   r_in_size;
    logic [LWIDTH:0]     r_pix_size;
    logic [DWIDTH-1:0]   r_bias;
    logic [LWIDTH-1:0]   r_pix_cnt;
    logic [CWIDTH-1:0]   r_ch_cnt;
    logic                r_out_valid;
    logic [LWIDTH-1:0]   r_out_addr;
    logic [DWIDTH-1:0]   r_out_data;
    logic                r_done;

    // Partial-sum buffer; deliberately not reset because channel 0 of every
    // job overwrites each entry before it is ever read.
    logic [c_BWIDTH-1:0] r_buf [0:c_DEPTH-1];

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic                w_accept;
    logic                w_last_pix;
    logic                w_last_ch;
    logic                w_first_ch;
    logic                w_single_ch;
    logic [LWIDTH:0]     w_pix_last_idx;
    logic [CWIDTH-1:0]   w_ch_last_idx;
    logic [c_BWIDTH-1:0] w_buf_rd;
    logic [c_BWIDTH-1:0] w_conv_ext_b;
    logic [c_BWIDTH-1:0] w_acc_base;
    logic [c_BWIDTH-1:0] w_acc_sum;
    logic [c_BWIDTH-1:0] w_fin_base;
    logic [c_SWIDTH-1:0] w_fin_base_ext;
    logic [c_SWIDTH-1:0] w_conv_ext_s;
    logic [c_SWIDTH-1:0] w_bias_ext_s;
    logic [c_SWIDTH-1:0] w_fin_sum;
    logic [c_HWIDTH-1:0] w_fin_hi;
    logic                w_ovf;
    logic [DWIDTH-1:0]   w_sat;
    logic [DWIDTH-1:0]   w_result;

    // A beat is only consumed while a job is running; idle beats are dropped.
    assign w_accept       = (r_state == c_S_ACC) && conv_valid;

    assign w_pix_last_idx = r_pix_size - (LWIDTH+1)'(1);
    assign w_ch_last_idx  = r_in_size - CWIDTH'(1);

    // pix_cnt is zero-extended so that pix_size = 2**LWIDTH compares cleanly.
    assign w_last_pix     = ({1'b0, r_pix_cnt} == w_pix_last_idx);
    assign w_last_ch      = (r_ch_cnt == w_ch_last_idx);
    assign w_first_ch     = (r_ch_cnt == '0);
    assign w_single_ch    = (r_in_size == CWIDTH'(1));

    // Combinational read of the entry for the pixel currently arriving.
    assign w_buf_rd       = r_buf[r_pix_cnt];

    // Non-last channel: channel 0 starts from zero instead of stale data.
    assign w_conv_ext_b   = {{CWIDTH{conv_data[DWIDTH-1]}}, conv_data};
    assign w_acc_base     = w_first_ch ? '0 : w_buf_rd;
    assign w_acc_sum      = w_acc_base + w_conv_ext_b;

    // Last channel: with a single channel the buffer is never consulted.
    assign w_fin_base     = w_single_ch ? '0 : w_buf_rd;
    assign w_fin_base_ext = {w_fin_base[c_BWIDTH-1], w_fin_base};
    assign w_conv_ext_s   = {{(c_SWIDTH-DWIDTH){conv_data[DWIDTH-1]}}, conv_data};
    assign w_bias_ext_s   = {{(c_SWIDTH-DWIDTH){r_bias[DWIDTH-1]}}, r_bias};
    assign w_fin_sum      = w_fin_base_ext + w_conv_ext_s + w_bias_ext_s;

    // The result fits in DWIDTH signed bits exactly when the sign bit of the
    // DWIDTH slice and every guard bit above it are identical.
    assign w_fin_hi       = w_fin_sum[c_SWIDTH-1:DWIDTH-1];
    assign w_ovf          = !((&w_fin_hi) || !(|w_fin_hi));

    always_comb begin
        w_sat = w_fin_sum[DWIDTH-1:0];
        if (w_ovf) begin
            w_sat = w_fin_sum[c_SWIDTH-1] ? c_SAT_MIN : c_SAT_MAX;
        end
    end

`ifdef RENKON_ACCUM_RELU_EN
    // Fused ReLU on the saturated value; shares the output register stage.
    assign w_result = w_sat[DWIDTH-1] ? '0 : w_sat;
`else
    assign w_result = w_sat;
`endif

    // ------------------------------------------------------------------
    // Control FSM, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state     <= c_S_IDLE;
            r_in_size   <= '0;
            r_pix_size  <= '0;
            r_bias      <= '0;
            r_pix_cnt   <= '0;
            r_ch_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            // Write strobe and done are single-cycle pulses.
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;

            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_in_size  <= in_size;
                        r_pix_size <= pix_size;
                        r_bias     <= bias;
                        r_pix_cnt  <= '0;
                        r_ch_cnt   <= '0;
                        r_state    <= c_S_ACC;
                    end
                end

                c_S_ACC: begin
                    if (conv_valid) begin
                        if (w_last_pix) begin
                            r_pix_cnt <= '0;
                            if (w_last_ch) begin
                                // Returning to idle here makes ack visible in
                                // the same cycle as the final out_valid/done,
                                // so a back-to-back start is possible.
                                r_state <= c_S_IDLE;
                            end else begin
                                r_ch_cnt <= r_ch_cnt + CWIDTH'(1);
                            end
                        end else begin
                            r_pix_cnt <= r_pix_cnt + LWIDTH'(1);
                        end

                        if (w_last_ch) begin
                            r_out_valid <= 1'b1;
                            r_out_addr  <= r_pix_cnt;
                            r_out_data  <= w_result;
                            r_done      <= w_last_pix;
                        end
                    end
                end

                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Partial-sum buffer write port (last channel bypasses the buffer)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept && !w_last_ch) begin
            r_buf[r_pix_cnt] <= w_acc_sum;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ack       = (r_state == c_S_IDLE);
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: doc/renkon_accum.md
Name: renkon_accum

Overview:
- Output-side companion of renkon_conv. Consumes the per-input-channel partial-sum pixel stream that renkon_conv produces.
- Accumulates partial sums across all input channels of one output map in an internal buffer.
- Adds the bias, saturates, and emits the finished output map as an addressed write stream to output memory.
- Sits between renkon_conv and the renkon output-memory write port.

Parameters:
- DWIDTH, 16: bit width of conv_data, bias and out_data (signed, two's complement).
- LWIDTH, 10: pixel address width; buffer depth is 2**LWIDTH.
- CWIDTH, 8: width of the input-channel count.

Ports:
- clk  in  1  system clock, rising edge.
- xrst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job start pulse; sampled only in S_IDLE.
- in_size  in  CWIDTH  number of input channels, 1..2**CWIDTH-1; latched on start.
- pix_size  in  LWIDTH+1  pixels per map, 1..2**LWIDTH; latched on start.
- bias  in  DWIDTH  signed bias for this output map; latched on start.
- conv_valid  in  1  conv_data carries one partial-sum pixel this cycle.
- conv_data  in  DWIDTH  signed partial sum from renkon_conv.
- ack  out  1  high while idle and able to accept start.
- out_valid  out  1  out_data/out_addr valid; acts as write enable to output memory.
- out_addr  out  LWIDTH  pixel index of out_data.
- out_data  out  DWIDTH  saturated final pixel.
- done  out  1  one-cycle pulse, coincident with the last out_valid of a job.

Behaviour:
- Reset (xrst=0, asynchronous):
  - state=S_IDLE; ack=1; out_valid=0, out_addr=0, out_data=0, done=0.
  - All counters and latched sizes cleared.
  - Buffer contents are not reset; channel 0 overwrites them.
- States:
  - S_IDLE --start--> S_ACC.
  - S_ACC --last pixel of last channel accepted--> S_IDLE.
  - ack=1 only in S_IDLE; ack drops the cycle after start.
- In S_IDLE, conv_valid is ignored. In S_ACC, start is ignored.
- Counters: pix_cnt runs 0..pix_size-1 and advances on each accepted conv_valid. On wrap to 0, ch_cnt increments. ch_cnt runs 0..in_size-1.
- Accumulation, non-last channel (ch_cnt < in_size-1):
  - buf[pix_cnt] <= (ch_cnt==0 ? 0 : buf[pix_cnt]) + sext(conv_data).
  - buf entries are DWIDTH+CWIDTH bits signed; no internal overflow is possible.
  - Buffer read is combinational from the register array at pix_cnt.
- Last channel (ch_cnt == in_size-1):
  - sum = (in_size==1 ? 0 : buf[pix_cnt]) + sext(conv_data) + sext(bias).
  - sum is saturated to [-2**(DWIDTH-1), 2**(DWIDTH-1)-1].
  - Registered to out_data with out_addr=pix_cnt and out_valid=1 on the next cycle.
  - The buffer is not written.
- Latency: one cycle from an accepted last-channel conv_valid to out_valid.
- Gaps in conv_valid are allowed anywhere; counters hold during gaps, and no out_valid is produced in gap cycles.
- done=1 together with out_valid for out_addr=pix_size-1. The FSM is already in S_IDLE (ack=1) in that cycle, so back-to-back start is legal in the done cycle.
- in_size=1: the pass-through path only (conv+bias, saturate); no buffer reads.
- pix_size=2**LWIDTH: pix_cnt still wraps cleanly to 0; out_addr covers the full range.
- Reset mid-job aborts immediately: no further out_valid, and no done for that job.

Optional Feature:
- Macro: RENKON_ACCUM_RELU_EN.
- Defined: after saturation, negative results are clamped to 0 before out_data (fused ReLU). This adds no latency.
- Undefined: out_data is the saturated signed value, negatives passed through.

Test Plan:
- Pass-through: start with in_size=1, pix_size=4, bias=10; conv_data 1,2,3,4 back-to-back -> out_valid for 4 cycles, addr 0..3, data 11,12,13,14; done with addr 3; ack=1 that cycle.
- Multi-channel with gaps: in_size=3, pix_size=2, bias=-1; ch0 {5,7}, ch1 {1,-2}, ch2 {3,4}, with conv_valid deasserted every other cycle -> out data 8 (addr 0) and 8 (addr 1), one cycle after each ch2 beat only.
- Saturation: DWIDTH=16, in_size=3, pix_size=1, bias=0; each channel 20000 -> out 32767. Each channel -20000 -> -32768 without the macro, 0 with RENKON_ACCUM_RELU_EN.
- Protocol robustness: conv_valid pulses while idle -> no out_valid. A second start during S_ACC -> ignored; job completes with original sizes. Back-to-back start in the done cycle -> second job runs correctly, and channel 0 overwrites the stale buffer.
- Reset mid-job: xrst low after 3 of 8 pixels of channel 1 -> outputs zero immediately, ack=1. A new job with in_size=2, pix_size=2 then yields correct sums with no stale data.
